// File: rtl/battery_share_ctrl_pkg.sv
// battery_ctrl_pkg: shared FSM states, mode codes and IEEE-754 exponent helpers
package battery_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CLASSIFY, ST_SETTLE, ST_RESULT} state_e;
  localparam logic [1:0] MODE_IDLE      = 2'd0;
  localparam logic [1:0] MODE_DISCHARGE = 2'd1;
  localparam logic [1:0] MODE_CHARGE    = 2'd2;
  localparam logic [1:0] MODE_ERR       = 2'd3;
  localparam logic [7:0] FP_EXP_ZERO    = 8'h00;
  localparam logic [7:0] FP_EXP_INF     = 8'hFF;
  function automatic logic soc_bad(input logic [8:0] sign_exp);
    return sign_exp[8] || sign_exp[7:0] == FP_EXP_ZERO || sign_exp[7:0] == FP_EXP_INF;
  endfunction
endpackage

// File: rtl/battery_share_ctrl_soc_validator.sv
// soc_validator: flags each SOC operand that is negative, zero/denormal, or inf/NaN
module soc_validator
  import battery_ctrl_pkg::*;
(
  input  logic [3:0][31:0] soc_i,
  output logic [3:0]       invalid_o
);
  logic unused_mant;
  assign unused_mant = ^{soc_i[3][22:0], soc_i[2][22:0], soc_i[1][22:0], soc_i[0][22:0]};
  for (genvar g = 0; g < 4; g++) begin : g_chk
    assign invalid_o[g] = soc_bad(soc_i[g][31:23]);
  end
endmodule

// File: rtl/battery_share_ctrl.sv
// battery_share_ctrl: sequences one current-split request through the sharing datapath
module battery_share_ctrl
  import battery_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] soc1_in,
  input  logic [31:0] soc2_in,
  input  logic [31:0] soc3_in,
  input  logic [31:0] soc4_in,
  input  logic [31:0] i_in,
  output logic [31:0] dp_soc1,
  output logic [31:0] dp_soc2,
  output logic [31:0] dp_soc3,
  output logic [31:0] dp_soc4,
  output logic [31:0] dp_i,
  output logic        dp_sel,
  output logic        dp_eqz,
  input  logic        dp_gt,
  input  logic        dp_lt,
  input  logic        dp_eq,
  input  logic [31:0] dp_i1,
  input  logic [31:0] dp_i2,
  input  logic [31:0] dp_i3,
  input  logic [31:0] dp_i4,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] i1_out,
  output logic [31:0] i2_out,
  output logic [31:0] i3_out,
  output logic [31:0] i4_out,
  output logic [1:0]  mode_out,
  output logic        err
);
  state_e            state_q, state_d;
  logic [3:0][31:0]  dp_soc_q, dp_soc_d, res_q, res_d;
  logic [31:0]       dp_i_q, dp_i_d;
  logic              sel_q, sel_d, eqz_q, eqz_d, err_q, err_d;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        invalid;
  soc_validator u_val (.soc_i(dp_soc_q), .invalid_o(invalid));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dp_soc_q <= '0;
      dp_i_q   <= '0;
      sel_q    <= 1'b0;
      eqz_q    <= 1'b1;
      err_q    <= 1'b0;
      mode_q   <= MODE_IDLE;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      dp_soc_q <= dp_soc_d;
      dp_i_q   <= dp_i_d;
      sel_q    <= sel_d;
      eqz_q    <= eqz_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    dp_soc_d = dp_soc_q;
    dp_i_d   = dp_i_q;
    sel_d    = sel_q;
    eqz_d    = eqz_q;
    err_d    = err_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    case (state_q)
      ST_IDLE: if (start_valid) begin
        dp_soc_d = {soc4_in, soc3_in, soc2_in, soc1_in};
        dp_i_d   = i_in;
        state_d  = ST_CLASSIFY;
      end
      ST_CLASSIFY: if (|invalid) begin
        err_d   = 1'b1;
        mode_d  = MODE_ERR;
        res_d   = '0;
        sel_d   = 1'b0;
        eqz_d   = 1'b1;
        state_d = ST_RESULT;
      end else begin
        err_d   = 1'b0;
        sel_d   = !dp_gt && dp_lt;
        eqz_d   = dp_eq || !(dp_gt || dp_lt);
        mode_d  = dp_gt ? MODE_DISCHARGE : dp_lt ? MODE_CHARGE : MODE_IDLE;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: if (cnt_q == '0) begin
        res_d   = {dp_i4, dp_i3, dp_i2, dp_i1};
        state_d = ST_RESULT;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      default: state_d = res_ready ? ST_IDLE : ST_RESULT;
    endcase
  end
  always_comb begin
    start_ready = state_q == ST_IDLE && !rst;
    res_valid   = state_q == ST_RESULT;
  end
  assign {dp_soc4, dp_soc3, dp_soc2, dp_soc1} = dp_soc_q;
  assign {i4_out, i3_out, i2_out, i1_out}     = res_q;
  assign dp_i     = dp_i_q;
  assign dp_sel   = sel_q;
  assign dp_eqz   = eqz_q;
  assign mode_out = mode_q;
  assign err      = err_q;
endmodule

// File: tb/tb_battery_share_ctrl.sv
// tb_battery_share_ctrl: directed scoreboard bench with a behavioural sharing datapath
module tb_battery_share_ctrl;
  import battery_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_valid = 1'b0, res_ready = 1'b1;
  logic [31:0] soc1_in = '0, soc2_in = '0, soc3_in = '0, soc4_in = '0, i_in = '0;
  logic start_ready, dp_sel, dp_eqz, dp_gt, dp_lt, dp_eq, res_valid, err;
  logic [31:0] dp_soc1, dp_soc2, dp_soc3, dp_soc4, dp_i, dp_i1, dp_i2, dp_i3, dp_i4;
  logic [31:0] i1_out, i2_out, i3_out, i4_out;
  logic [1:0] mode_out;
  typedef struct {
    logic [3:0][31:0] cur;
    logic [1:0]       mode;
    logic             err, sel, eqz;
    int               lat;
    logic [31:0]      iv;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] dp_fn(logic [31:0] s, logic [31:0] iv, logic sel, logic eqz, int k);
    return eqz ? 32'd0 : (s ^ iv ^ {31'd0, sel}) + 32'(k);
  endfunction
  // behavioural stand-in for the comparator/divide/split datapath
  assign dp_gt = !dp_i[31] && dp_i[30:23] != 8'h00;
  assign dp_lt = dp_i[31] && dp_i[30:23] != 8'h00;
  assign dp_eq = dp_i[30:0] == 31'd0;
  assign dp_i1 = dp_fn(dp_soc1, dp_i, dp_sel, dp_eqz, 1);
  assign dp_i2 = dp_fn(dp_soc2, dp_i, dp_sel, dp_eqz, 2);
  assign dp_i3 = dp_fn(dp_soc3, dp_i, dp_sel, dp_eqz, 3);
  assign dp_i4 = dp_fn(dp_soc4, dp_i, dp_sel, dp_eqz, 4);
  battery_share_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .soc1_in(soc1_in), .soc2_in(soc2_in), .soc3_in(soc3_in), .soc4_in(soc4_in), .i_in(i_in),
    .dp_soc1(dp_soc1), .dp_soc2(dp_soc2), .dp_soc3(dp_soc3), .dp_soc4(dp_soc4), .dp_i(dp_i),
    .dp_sel(dp_sel), .dp_eqz(dp_eqz), .dp_gt(dp_gt), .dp_lt(dp_lt), .dp_eq(dp_eq),
    .dp_i1(dp_i1), .dp_i2(dp_i2), .dp_i3(dp_i3), .dp_i4(dp_i4),
    .res_valid(res_valid), .res_ready(res_ready),
    .i1_out(i1_out), .i2_out(i2_out), .i3_out(i3_out), .i4_out(i4_out),
    .mode_out(mode_out), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic bad_soc(logic [31:0] s);
    return s[31] || s[30:23] == 8'h00 || s[30:23] == 8'hFF;
  endfunction
  task automatic send(input logic [31:0] s1, s2, s3, s4, iv);
    exp_t e;
    int n = 0;
    while (!start_ready && n < 50) begin
      tick();
      n++;
    end
    chk("start_ready_before_req", {31'd0, start_ready}, 32'd1);
    e.iv = iv;
    if (bad_soc(s1) || bad_soc(s2) || bad_soc(s3) || bad_soc(s4)) begin
      e.err = 1'b1; e.mode = MODE_ERR; e.sel = 1'b0; e.eqz = 1'b1; e.lat = 2; e.cur = '0;
    end else begin
      e.err = 1'b0; e.lat = 6;
      e.sel = iv[30:23] != 8'h00 && iv[31];
      e.eqz = iv[30:23] == 8'h00;
      e.mode = e.eqz ? MODE_IDLE : iv[31] ? MODE_CHARGE : MODE_DISCHARGE;
      e.cur = {dp_fn(s4, iv, e.sel, e.eqz, 4), dp_fn(s3, iv, e.sel, e.eqz, 3),
               dp_fn(s2, iv, e.sel, e.eqz, 2), dp_fn(s1, iv, e.sel, e.eqz, 1)};
    end
    {soc1_in, soc2_in, soc3_in, soc4_in, i_in} = {s1, s2, s3, s4, iv};
    start_valid = 1'b1;
    tick();
    acc_cyc = cyc;
    start_valid = 1'b0;
    q.push_back(e);
  endtask
  task automatic check_sel(input string tag);
    tick();
    chk({tag, "_dp_sel"}, {31'd0, dp_sel}, {31'd0, q[$].sel});
    chk({tag, "_dp_eqz"}, {31'd0, dp_eqz}, {31'd0, q[$].eqz});
  endtask
  task automatic get_res(input string tag, output exp_t e);
    int n = 0;
    while (!res_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
    if (q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      e = '{cur: '0, mode: 2'd0, err: 1'b0, sel: 1'b0, eqz: 1'b0, lat: 0, iv: '0};
    end else begin
      e = q.pop_front();
      chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(e.lat));
      chk({tag, "_mode"}, {30'd0, mode_out}, {30'd0, e.mode});
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
      chk({tag, "_i1"}, i1_out, e.cur[0]);
      chk({tag, "_i2"}, i2_out, e.cur[1]);
      chk({tag, "_i3"}, i3_out, e.cur[2]);
      chk({tag, "_i4"}, i4_out, e.cur[3]);
    end
  endtask
  task automatic finish_res(input string tag);
    tick();
    chk({tag, "_res_valid_drop"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_start_ready_back"}, {31'd0, start_ready}, 32'd1);
  endtask
  task automatic run(input string tag, input logic [31:0] s1, s2, s3, s4, iv);
    exp_t e;
    send(s1, s2, s3, s4, iv);
    check_sel(tag);
    get_res(tag, e);
    finish_res(tag);
  endtask
  initial begin
    exp_t e;
    tick();
    chk("rst_start_ready", {31'd0, start_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_dp_eqz", {31'd0, dp_eqz}, 32'd1);
    chk("rst_dp_sel", {31'd0, dp_sel}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_mode", {30'd0, mode_out}, {30'd0, MODE_IDLE});
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_i1", i1_out, 32'd0);
    chk("rst_dp_i", dp_i, 32'd0);
    chk("rst_dp_soc1", dp_soc1, 32'd0);
    chk("rst_start_ready_after", {31'd0, start_ready}, 32'd1);
    run("discharge", 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000);
    run("charge",    32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'hC1200000);
    run("zero_i",    32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000000);
    run("denorm_i",  32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h00000001);
    run("neg_soc3",  32'h3f800000, 32'h40000000, 32'hBF800000, 32'h40800000, 32'h41200000);
    run("inf_soc2",  32'h3f800000, 32'h7F800000, 32'h40400000, 32'h40800000, 32'hC1200000);
    run("zero_soc4", 32'h3f800000, 32'h40000000, 32'h40400000, 32'h00000000, 32'h41200000);
    run("charge2",   32'h3f000000, 32'h3e800000, 32'h3f400000, 32'h3f600000, 32'hC0A00000);
    res_ready = 1'b0;
    send(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41A00000);
    get_res("stall", e);
    for (int k = 0; k < 10; k++) begin
      start_valid = k[0];
      i_in = 32'h12345678;
      tick();
      chk("stall_res_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_start_ready", {31'd0, start_ready}, 32'd0);
      chk("stall_i1", i1_out, e.cur[0]);
      chk("stall_i4", i4_out, e.cur[3]);
      chk("stall_mode", {30'd0, mode_out}, {30'd0, e.mode});
      chk("stall_dp_i", dp_i, e.iv);
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    finish_res("stall");
    send(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h41200000);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_i1", i1_out, 32'd0);
    chk("abort_dp_eqz", {31'd0, dp_eqz}, 32'd1);
    chk("abort_start_ready_in_rst", {31'd0, start_ready}, 32'd0);
    void'(q.pop_back());
    rst = 1'b0;
    #1;
    chk("abort_start_ready", {31'd0, start_ready}, 32'd1);
    run("after_abort", 32'h40000000, 32'h40400000, 32'h40800000, 32'h3f800000, 32'hC1200000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
